// File: rtl/rsqrtf_pkg.sv
// Shared types and constants for the rsqrtf stream adapter and its bench.
package rsqrtf_pkg;
    localparam int RSQRTF_LATENCY = 12;
    localparam int FP32_W = 32;
    localparam int RSQRTF_TAG_W = 8;

    typedef struct packed {
        logic [RSQRTF_TAG_W-1:0] tag;
        logic [FP32_W-1:0]       fp32;
    } rsqrtf_entry_t;
endpackage

// File: rtl/rsqrtf_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on dout whenever !empty.
module rsqrtf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    occ,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign occ     = CW'(wr_ptr - rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rsqrtf_stream_adapter.sv
// Valid/ready front/back end for the rsqrtf core with credit-based issue so
// the non-backpressurable result strobe always has a buffer slot waiting.
module rsqrtf_stream_adapter
    import rsqrtf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_tdata,
    input  logic [TAG_W-1:0]  s_tuser,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [31:0]       core_x,
    output logic              core_xvld,
    input  logic              core_xrdy,
    input  logic [31:0]       core_r,
    input  logic              core_rvld,
    output logic [31:0]       m_tdata,
    output logic [TAG_W-1:0]  m_tuser,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [CW-1:0]     inflight,
    output logic              err
);
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [FP32_W-1:0] fp32;
    } entry_t;

    entry_t           res_in, res_out;
    logic [CW-1:0]    res_occ;
    logic             res_full, res_empty;
    logic [TAG_W-1:0] tag_head;
    logic             tag_full, tag_empty;
    logic [CW:0]      used;
    logic             credit_ok, issue, take, res_pop;
    logic             unused_tag_full;

    // Tag FIFO occupancy is exactly the number of requests awaiting a result.
    rsqrtf_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk(clk), .rst(rst),
        .push(issue), .din(s_tuser),
        .pop(take), .dout(tag_head),
        .occ(inflight), .full(tag_full), .empty(tag_empty)
    );

    rsqrtf_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_res_fifo (
        .clk(clk), .rst(rst),
        .push(take && !res_full), .din(res_in),
        .pop(res_pop), .dout(res_out),
        .occ(res_occ), .full(res_full), .empty(res_empty)
    );

    // Both terms are registered, so a pop only returns credit next cycle.
    assign used      = {1'b0, res_occ} + {1'b0, inflight};
    assign credit_ok = (used < (CW+1)'(DEPTH));
    assign s_tready  = core_xrdy && credit_ok && !rst;
    assign core_xvld = s_tvalid && credit_ok && !rst;
    assign core_x    = s_tdata;
    assign issue     = s_tvalid && s_tready;

    assign take        = core_rvld && !tag_empty;
    assign res_in.tag  = tag_head;
    assign res_in.fp32 = core_r;

    assign m_tvalid = !res_empty;
    assign m_tdata  = res_out.fp32;
    assign m_tuser  = res_out.tag;
    assign res_pop  = m_tvalid && m_tready;

    assign unused_tag_full = tag_full;

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (core_rvld && (tag_empty || res_full))
            err <= 1'b1;
    end
endmodule

// File: tb/tb_rsqrtf_stream_adapter.sv
// Bench: core model plus queue-level adapter model checked every cycle.
module tb_rsqrtf_stream_adapter;
    import rsqrtf_pkg::*;
    localparam int DEPTH = 4;
    localparam int TAG_W = 8;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk, rst;
    logic [31:0] s_tdata, core_x, core_r, m_tdata;
    logic [TAG_W-1:0] s_tuser, m_tuser;
    logic s_tvalid, s_tready, core_xvld, core_xrdy, core_rvld, m_tvalid, m_tready, err;
    logic [CW-1:0] inflight;

    int checks = 0, errors = 0;
    int n_issue = 0, n_out = 0;
    logic [7:0] last_tag;
    logic [31:0] last_data;

    bit rand_lat = 0;
    bit core_busy = 0;
    int core_cnt = 0;
    logic [31:0] core_xl;
    int inject_req = 0, inject_ack = 0;

    rsqrtf_entry_t exp_q[$], issue_log[$];
    logic [7:0] tag_q[$];
    bit m_err = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    rsqrtf_stream_adapter #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .core_x(core_x), .core_xvld(core_xvld), .core_xrdy(core_xrdy),
        .core_r(core_r), .core_rvld(core_rvld),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .inflight(inflight), .err(err)
    );

    // Exact for even powers of two; anything else gets an arbitrary marker value.
    function automatic logic [31:0] rsqrt_model(input logic [31:0] x);
        int u;
        if (x[22:0] == 0 && !x[31] && x[30:23] != 0) begin
            u = int'(x[30:23]) - 127;
            if (u % 2 == 0) return {1'b0, 8'(127 - u / 2), 23'h0};
        end
        return x ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Time-rolled core: one request at a time, result strobe after core_cnt cycles.
    initial begin
        bit rs, fire;
        logic [31:0] xs;
        core_xrdy = 1; core_rvld = 0; core_r = 0;
        forever begin
            @(negedge clk);
            rs = rst; fire = core_xvld && core_xrdy; xs = core_x;
            @(posedge clk); #1;
            if (rs) begin
                core_busy = 0; core_rvld = 0; core_xrdy = 1;
            end else begin
                if (core_rvld) begin core_rvld = 0; core_xrdy = 1; end
                if (fire) begin
                    core_busy = 1; core_xl = xs; core_xrdy = 0;
                    core_cnt = rand_lat ? int'($urandom_range(1, 15)) : RSQRTF_LATENCY;
                end else if (core_busy) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        core_rvld = 1; core_r = rsqrt_model(core_xl); core_busy = 0;
                    end
                end
                if (inject_req != inject_ack) begin
                    inject_ack++; core_rvld = 1; core_r = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Queue model of the adapter; checks outputs, then advances over the next edge.
    initial begin
        bit cred, full_before;
        rsqrtf_entry_t e, l;
        logic [7:0] t;
        forever begin
            @(negedge clk);
            cred = (exp_q.size() + tag_q.size()) < DEPTH;
            chk("core_x", core_x, s_tdata);
            if (rst) begin
                chk("s_tready_rst", s_tready, 0);
                chk("core_xvld_rst", core_xvld, 0);
                exp_q.delete(); tag_q.delete(); issue_log.delete(); m_err = 0;
            end else begin
                chk("m_tvalid", m_tvalid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk("m_tdata", m_tdata, exp_q[0].fp32);
                    chk("m_tuser", m_tuser, exp_q[0].tag);
                end
                chk("inflight", inflight, tag_q.size());
                chk("err", err, m_err);
                chk("s_tready", s_tready, core_xrdy && cred);
                chk("core_xvld", core_xvld, s_tvalid && cred);
                full_before = exp_q.size() == DEPTH;
                if (exp_q.size() != 0 && m_tready) begin
                    e = exp_q.pop_front();
                    n_out++; last_tag = e.tag; last_data = e.fp32;
                    if (issue_log.size() == 0) chk("order_extra", 1, 0);
                    else begin
                        l = issue_log.pop_front();
                        chk("order_tag", e.tag, l.tag);
                        chk("order_data", e.fp32, l.fp32);
                    end
                end
                if (core_rvld) begin
                    if (tag_q.size() == 0) m_err = 1;
                    else begin
                        t = tag_q.pop_front();
                        if (full_before) m_err = 1;
                        else exp_q.push_back('{tag: t, fp32: core_r});
                    end
                end
                if (s_tvalid && core_xrdy && cred) begin
                    tag_q.push_back(s_tuser);
                    issue_log.push_back('{tag: s_tuser, fp32: rsqrt_model(s_tdata)});
                    n_issue++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [7:0] t);
        bit ok = 0;
        step();
        s_tvalid = 1; s_tdata = x; s_tuser = t;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_tready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        step();
        s_tvalid = 0;
    endtask

    task automatic drain();
        bit ok = 0;
        step();
        m_tready = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (inflight == 0 && !m_tvalid) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int rv_cyc, mv_cyc, bo, bi;
        bit hs, ok;
        logic [31:0] cap_d;
        logic [7:0] cap_t;
        rst = 1; s_tvalid = 0; s_tdata = 0; s_tuser = 0; m_tready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_m_tvalid", m_tvalid, 0);
        chk("reset_inflight", inflight, 0);
        chk("reset_err", err, 0);

        // Single op: 4.0 -> 0.5, result one clock after the core strobe.
        step(); m_tready = 1;
        send(32'h4080_0000, 8'h11);
        @(negedge clk);
        chk("t1_inflight_1", inflight, 1);
        rv_cyc = -10; mv_cyc = -1; cap_d = 0; cap_t = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_rvld) rv_cyc = i;
            if (m_tvalid) begin mv_cyc = i; cap_d = m_tdata; cap_t = m_tuser; break; end
        end
        chk("t1_latency", mv_cyc - rv_cyc, 1);
        chk("t1_data", cap_d, 32'h3F00_0000);
        chk("t1_tag", cap_t, 8'h11);
        @(negedge clk);
        chk("t1_inflight_0", inflight, 0);

        // Burst of 8: 1, 4, 16, ... tags 0..7.
        bo = n_out;
        for (int k = 0; k < 8; k++) send(32'h3F80_0000 + (32'(k) << 24), 8'(k));
        drain();
        chk("t2_count", n_out - bo, 8);
        chk("t2_last_tag", last_tag, 8'h07);
        chk("t2_last_data", last_data, 32'h3C00_0000);
        chk("t2_err", err, 0);

        // Backpressure: only DEPTH of 6 offered ops may issue.
        step(); m_tready = 0;
        bo = n_out; bi = n_issue;
        for (int k = 0; k < 4; k++) send(32'h4180_0000, 8'h30 + 8'(k));
        step(); s_tvalid = 1; s_tdata = 32'h4080_0000; s_tuser = 8'h34;
        repeat (40) @(negedge clk);
        chk("t3_s_tready", s_tready, 0);
        chk("t3_inflight", inflight, 0);
        chk("t3_m_tvalid", m_tvalid, 1);
        chk("t3_issued", n_issue - bi, 4);
        step(); m_tready = 1;
        send(32'h4080_0000, 8'h34);
        send(32'h4180_0000, 8'h35);
        drain();
        chk("t3_count", n_out - bo, 6);
        chk("t3_last_tag", last_tag, 8'h35);

        // Pop and result strobe in the same cycle with 3 results buffered.
        step(); m_tready = 0;
        bo = n_out;
        for (int k = 0; k < 4; k++) send(32'h3F80_0000, 8'h40 + 8'(k));
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_busy && core_cnt == 1) begin ok = 1; break; end
        end
        chk("t4_wait", ok, 1);
        step(); m_tready = 1;
        @(negedge clk);
        chk("t4_rvld", core_rvld, 1);
        chk("t4_both", m_tvalid, 1);
        step(); m_tready = 0;
        @(negedge clk);
        chk("t4_inflight", inflight, 0);
        chk("t4_popped", n_out - bo, 1);
        chk("t4_first_tag", last_tag, 8'h40);
        step(); m_tready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_occ3_valid", m_tvalid, 1);
        end
        @(negedge clk);
        chk("t4_occ3_empty", m_tvalid, 0);
        chk("t4_last_tag", last_tag, 8'h43);
        chk("t4_err", err, 0);

        // Spurious strobe with nothing in flight.
        inject_req++;
        @(negedge clk);
        @(negedge clk);
        chk("t5_err_set", err, 1);
        chk("t5_m_tvalid", m_tvalid, 0);
        repeat (5) @(negedge clk);
        chk("t5_err_sticky", err, 1);
        chk("t5_inflight", inflight, 0);
        step(); rst = 1;
        step(); rst = 0;
        @(negedge clk);
        chk("t5_err_clear", err, 0);

        // Reset mid-operation, then a clean op.
        send(32'h4080_0000, 8'h33);
        repeat (4) step();
        rst = 1;
        step(); step(); rst = 0;
        bo = n_out;
        repeat (30) @(negedge clk);
        chk("t6_no_out", n_out - bo, 0);
        chk("t6_m_tvalid", m_tvalid, 0);
        chk("t6_inflight", inflight, 0);
        send(32'h4180_0000, 8'h22);
        drain();
        chk("t6_count", n_out - bo, 1);
        chk("t6_tag", last_tag, 8'h22);
        chk("t6_data", last_data, 32'h3E80_0000);

        // Random traffic with random core latency and downstream stalls.
        rand_lat = 1;
        bo = n_out; bi = n_issue; hs = 0;
        step();
        for (int c = 0; c < 1500; c++) begin
            if (!s_tvalid || hs) begin
                s_tvalid = ($urandom_range(0, 2) != 0);
                s_tdata = {1'b0, 8'(127 + 2 * int'($urandom_range(0, 40)) - 40), 23'h0};
                s_tuser = 8'($urandom);
            end
            m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs = s_tvalid && s_tready;
            step();
        end
        s_tvalid = 0;
        drain();
        chk("rand_balance", n_out - bo, n_issue - bi);
        chk("rand_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
